// File: rtl/gpu_pkg.sv
// Shared vertex types so neighbouring geometry stages agree on coordinate width.
package gpu_pkg;
    localparam int COORD_W  = 10;
    localparam int NUM_AXES = 3;

    typedef logic signed [COORD_W-1:0] coord_t;
endpackage

// File: rtl/divide_by_two.sv
// Signed floor(a/2) (rounds toward -inf), purely combinational; output is one bit narrower
// because the halved value of a WIDTH-bit signed number always fits in WIDTH-1 bits.
module divide_by_two #(
    parameter int WIDTH = 11
) (
    input  logic signed [WIDTH-1:0] a_i,
    output logic signed [WIDTH-2:0] q_o
);
    // Dropping the LSB of a two's complement value is exactly an arithmetic floor-halve.
    logic unused_lsb;
    assign {q_o, unused_lsb} = a_i;
endmodule

// File: rtl/vertex_midpoint_pipe.sv
// Edge-subdivision midpoint floor((V0+V1)/2) per axis: 2-stage valid/ready pipe, 2-cycle latency,
// full throughput; stalls in_ready only when both stages hold data and out_ready is low.
module vertex_midpoint_pipe
    import gpu_pkg::*;
#(
    parameter int WIDTH = COORD_W,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_x0,
    input  logic signed [WIDTH-1:0] in_y0,
    input  logic signed [WIDTH-1:0] in_z0,
    input  logic signed [WIDTH-1:0] in_x1,
    input  logic signed [WIDTH-1:0] in_y1,
    input  logic signed [WIDTH-1:0] in_z1,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_x,
    output logic signed [WIDTH-1:0] out_y,
    output logic signed [WIDTH-1:0] out_z,
    output logic                    busy,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        mid_count
);
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_load, s2_load;
    logic out_fire;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic signed [WIDTH-1:0] v0  [NUM_AXES];
    logic signed [WIDTH-1:0] v1  [NUM_AXES];
    logic signed [WIDTH-1:0] mid [NUM_AXES];

    assign v0[0] = in_x0;
    assign v0[1] = in_y0;
    assign v0[2] = in_z0;
    assign v1[0] = in_x1;
    assign v1[1] = in_y1;
    assign v1[2] = in_z1;

    always_comb begin
        s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready   = !s1_valid_q || s2_load;
        s1_load    = in_valid && in_ready;
        s1_valid_d = s1_load | (s1_valid_q & !s2_load);
        s2_valid_d = s2_load | (s2_valid_q & !out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
        logic signed [WIDTH:0]   sum_d, sum_q;
        logic signed [WIDTH-1:0] half;
        logic signed [WIDTH-1:0] mid_q;

        // One guard bit keeps the sum exact for any pair of coordinates.
        assign sum_d = {v0[a][WIDTH-1], v0[a]} + {v1[a][WIDTH-1], v1[a]};

        divide_by_two #(.WIDTH(WIDTH + 1)) u_div (
            .a_i (sum_q),
            .q_o (half)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
                mid_q <= '0;
            end else begin
                if (s1_load) sum_q <= sum_d;
                if (s2_load) mid_q <= half;
            end
        end

        assign mid[a] = mid_q;
    end

    assign out_valid = s2_valid_q;
    assign out_x     = mid[0];
    assign out_y     = mid[1];
    assign out_z     = mid[2];
    assign busy      = s1_valid_q | s2_valid_q;
    assign out_fire  = s2_valid_q && out_ready;

    // Clear wins over a same-cycle delivery; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_fire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mid_count = cnt_q;
endmodule

// File: tb/tb_vertex_midpoint_pipe.sv
// Randomized bench for vertex_midpoint_pipe: scoreboard of floor midpoints plus directed corner cases.
module tb_vertex_midpoint_pipe;
    import gpu_pkg::*;

    logic   clk = 1'b0;
    always #5 clk = ~clk;

    logic   rst_n, in_valid, out_ready, cnt_clr;
    coord_t in_x0, in_y0, in_z0, in_x1, in_y1, in_z1;

    logic        in_ready, out_valid, busy;
    coord_t      out_x, out_y, out_z;
    logic [15:0] mid_count;

    logic        in_ready4, out_valid4, busy4;
    coord_t      out_x4, out_y4, out_z4;
    logic [3:0]  mid_count4;

    vertex_midpoint_pipe #(.WIDTH(COORD_W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x0(in_x0), .in_y0(in_y0), .in_z0(in_z0),
        .in_x1(in_x1), .in_y1(in_y1), .in_z1(in_z1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .busy(busy), .cnt_clr(cnt_clr), .mid_count(mid_count)
    );

    vertex_midpoint_pipe #(.WIDTH(COORD_W), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_x0(in_x0), .in_y0(in_y0), .in_z0(in_z0),
        .in_x1(in_x1), .in_y1(in_y1), .in_z1(in_z1),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_x(out_x4), .out_y(out_y4), .out_z(out_z4),
        .busy(busy4), .cnt_clr(cnt_clr), .mid_count(mid_count4)
    );

    int n_checks = 0;
    int n_errors = 0;
    int qx[$], qy[$], qz[$];
    int out_cycles[$];
    int exp_cnt  = 0;
    int exp_cnt4 = 0;
    int cyc      = 0;
    bit last_in_fire;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: mathematical floor of the average, from integer arithmetic.
    function automatic int mid_ref(input int a, input int b);
        int s, m;
        s = a + b;
        m = s / 2;
        if (s < 0 && (s % 2) != 0) m = m - 1;
        return m;
    endfunction

    // Called just after a falling edge with inputs driven; observes handshakes, advances one cycle.
    task automatic step();
        int ex, ey, ez;
        #1;
        last_in_fire = in_valid && in_ready;
        if (last_in_fire) begin
            qx.push_back(mid_ref(int'(in_x0), int'(in_x1)));
            qy.push_back(mid_ref(int'(in_y0), int'(in_y1)));
            qz.push_back(mid_ref(int'(in_z0), int'(in_z1)));
        end
        if (out_valid && out_ready) begin
            if (qx.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                ex = qx.pop_front();
                ey = qy.pop_front();
                ez = qz.pop_front();
                check("out_x", int'(out_x), ex);
                check("out_y", int'(out_y), ey);
                check("out_z", int'(out_z), ez);
                check("out4_valid", int'(out_valid4), 1);
                check("out4_x", int'(out_x4), ex);
            end
            out_cycles.push_back(cyc);
            if (exp_cnt < 65535) exp_cnt++;
            if (exp_cnt4 < 15) exp_cnt4++;
        end
        if (cnt_clr) begin
            exp_cnt  = 0;
            exp_cnt4 = 0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("mid_count", int'(mid_count), exp_cnt);
        check("mid_count4", int'(mid_count4), exp_cnt4);
    endtask

    task automatic drive_pair(input int x0, input int y0, input int z0,
                              input int x1, input int y1, input int z1);
        in_x0 = coord_t'(x0); in_y0 = coord_t'(y0); in_z0 = coord_t'(z0);
        in_x1 = coord_t'(x1); in_y1 = coord_t'(y1); in_z1 = coord_t'(z1);
        in_valid = 1'b1;
    endtask

    task automatic send(input int x0, input int y0, input int z0,
                        input int x1, input int y1, input int z1);
        drive_pair(x0, y0, z0, x1, y1, z1);
        for (int t = 0; t < 200; t++) begin
            step();
            if (last_in_fire) break;
        end
        if (!last_in_fire) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send($urandom_range(0, 1023) - 512, $urandom_range(0, 1023) - 512,
             $urandom_range(0, 1023) - 512, $urandom_range(0, 1023) - 512,
             $urandom_range(0, 1023) - 512, $urandom_range(0, 1023) - 512);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (qx.size() == 0) break;
            step();
        end
        check("drain_empty", qx.size(), 0);
        check("drain_idle", int'(out_valid), 0);
    endtask

    // Single pair with a directed expected midpoint, checked the cycle after S1 loads.
    task automatic directed(input string tag, input int x0, input int y0, input int z0,
                            input int x1, input int y1, input int z1,
                            input int mx, input int my, input int mz);
        out_ready = 1'b1;
        send(x0, y0, z0, x1, y1, z1);
        check({tag, "_not_yet"}, int'(out_valid), 0);
        step();
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_x"}, int'(out_x), mx);
        check({tag, "_y"}, int'(out_y), my);
        check({tag, "_z"}, int'(out_z), mz);
        drain();
    endtask

    initial begin
        #400000;
        check("watchdog", 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        int gaps, start;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        drive_pair(0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_mid_count", int'(mid_count), 0);
        check("rst_out_x", int'(out_x), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        directed("basic", 10, 20, 30, 20, 40, -30, 15, 30, 0);
        directed("round", -3, 3, 0, 0, 0, 0, -2, 1, 0);
        directed("extreme", 511, -512, 511, 511, -512, -512, 511, -512, -1);

        // Backpressure: third pair must wait while both stages are full.
        out_ready = 1'b0;
        send(1, 2, 3, 5, 6, 7);
        send(-8, -9, -10, 100, 200, 300);
        drive_pair(7, 7, 7, -7, -7, -7);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_busy", int'(busy), 1);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_hold_x", int'(out_x), qx[0]);
            check("bp_hold_z", int'(out_z), qz[0]);
        end
        out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            step();
            if (last_in_fire) break;
        end
        check("bp_third_accepted", int'(last_in_fire), 1);
        drain();

        // Streaming with out_ready held high: back-to-back outputs.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        out_ready = 1'b1;
        start = out_cycles.size();
        for (int i = 0; i < 100; i++) send_rand();
        drain();
        check("stream_count", out_cycles.size() - start, 100);
        gaps = 0;
        for (int i = start + 1; i < out_cycles.size(); i++)
            if (out_cycles[i] != out_cycles[i-1] + 1) gaps++;
        check("stream_gaps", gaps, 0);
        check("stream_mid_count", int'(mid_count), 100);
        check("stream_mid_count4_sat", int'(mid_count4), 15);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("cnt_clr", int'(mid_count), 0);

        // Clear coinciding with an output transfer.
        send(4, 4, 4, 6, 6, 6);
        step();
        check("prio_pending", int'(out_valid), 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_priority", int'(mid_count), 0);

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send(1, 1, 1, 1, 1, 1);
        send(2, 2, 2, 2, 2, 2);
        check("full_busy", int'(busy), 1);
        check("full_in_ready", int'(in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_mid_count", int'(mid_count), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_busy4", int'(busy4), 0);
        check("mid_rst_in_ready4", int'(in_ready4), 1);
        qx.delete(); qy.delete(); qz.delete();
        exp_cnt = 0; exp_cnt4 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_idle", int'(out_valid), 0);
        directed("post_rst", 100, -100, 9, 50, -51, 0, 75, -76, 4);

        // Narrow counter saturation: 20 more transfers from a count of 1.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) send_rand();
        drain();
        check("cnt4_saturate", int'(mid_count4), 15);
        check("cnt16_after_sat", int'(mid_count), 21);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
